alu_pipe: RTL

//  Parametrised, handshaked successor to the single-cycle execute-stage ALU.
//  - Sits between the register-read and memory stages of the CPU pipeline.
//  - Computes arithmetic, logic, shift and address results with valid/ready flow control.
//  - Keeps the architectural Z/V/N flag register.
//  - Optionally adds a multi-cycle shift-add multiplier that back-pressures the decoder.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_mul_iter.sv | 56 +++++
 rtl/alu_pipe.sv | 127 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and overflow helpers for the execute ALU.
// Optional multiplier opcode is enabled by ALU_MUL_EN.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4;
  localparam logic [3:0] OP_SRL = 4'd5;
  localparam logic [3:0] OP_SRA = 4'd6;
  localparam logic [3:0] OP_RL  = 4'd7;
  localparam logic [3:0] OP_LW  = 4'd8;
  localparam logic [3:0] OP_SW  = 4'd9;
  localparam logic [3:0] OP_LLB = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  // Signed overflow from operand/result sign bits.
  function automatic logic ovf(
    input logic sa,
    input logic sb,
    input logic sr,
    input logic sub
  );
    if (sub)
      return (sa != sb) && (sr != sa);
    return (sa == sb) && (sr != sa);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier, one partial product per cycle.
// Used by alu_pipe only when ALU_MUL_EN is defined.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter  int DSIZE = 16,
  localparam int SHW   = $clog2(DSIZE),
  localparam int PW    = 2 * DSIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DSIZE-1:0] a,
  input  logic [DSIZE-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [PW-1:0]    prod
);

  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [DSIZE-1:0] mplier;
  logic [SHW-1:0]   cnt;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    nxt;

  assign addend = mplier[0] ? mcand : '0;
  assign nxt    = acc + addend;
  // Final step is folded in combinationally so done lands on the last iteration.
  assign done   = busy && (cnt == SHW'(DSIZE - 1));
  assign prod   = nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{DSIZE{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done)
        busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked execute-stage ALU with Z/V/N flag register.
// Define ALU_MUL_EN to add the iterative MUL opcode.
module alu_pipe
  import alu_pkg::*;
#(
  parameter  int DSIZE = 16,
  localparam int SHW   = $clog2(DSIZE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] data1,
  input  logic [DSIZE-1:0] data2,
  input  logic [3:0]       op,
  input  logic [SHW-1:0]   imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] out,
  output logic [2:0]       flag
);

  localparam int M = DSIZE - 1;

  logic               accept;
  logic               is_mul;
  logic               mul_busy;
  logic               mul_done;
  logic [2*DSIZE-1:0] mul_prod;
  logic [DSIZE-1:0]   sum;
  logic [DSIZE-1:0]   diff;
  logic [2*DSIZE-1:0] rot;
  logic [DSIZE-1:0]   res;
  logic               v;
  logic               upd_zv;
  logic               upd_n;

  assign in_ready = ~mul_busy & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

`ifdef ALU_MUL_EN
  assign is_mul = (op == OP_MUL);

  alu_mul_iter #(.DSIZE(DSIZE)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept & is_mul),
    .a     (data1),
    .b     (data2),
    .busy  (mul_busy),
    .done  (mul_done),
    .prod  (mul_prod)
  );
`else
  assign is_mul   = 1'b0;
  assign mul_busy = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
`endif

  assign sum  = data1 + data2;
  assign diff = data1 - data2;
  // Doubled operand avoids the DSIZE-imm wrap when imm is zero.
  assign rot  = {data1, data1} << imm;

  always_comb begin
    res    = '0;
    v      = 1'b0;
    upd_zv = 1'b0;
    upd_n  = 1'b0;
    unique case (1'b1)
      (op == OP_ADD): begin
        res    = sum;
        v      = ovf(data1[M], data2[M], sum[M], 1'b0);
        upd_zv = 1'b1;
        upd_n  = 1'b1;
      end
      (op == OP_SUB): begin
        res    = diff;
        v      = ovf(data1[M], data2[M], diff[M], 1'b1);
        upd_zv = 1'b1;
        upd_n  = 1'b1;
      end
      (op == OP_AND): begin
        res    = data1 & data2;
        upd_zv = 1'b1;
      end
      (op == OP_OR): begin
        res    = data1 | data2;
        upd_zv = 1'b1;
      end
      (op == OP_SLL): res = data1 << imm;
      (op == OP_SRL): res = data1 >> imm;
      (op == OP_SRA): res = $signed(data1) >>> imm;
      (op == OP_RL):  res = rot[2*DSIZE-1:DSIZE];
      (op == OP_LW):  res = sum;
      (op == OP_SW):  res = sum;
      (op == OP_LLB): res = data1 & data2;
      default:        res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      flag      <= 3'b000;
    end else if (accept && !is_mul) begin
      out       <= res;
      out_valid <= 1'b1;
      if (upd_zv) begin
        flag[FLAG_Z] <= (res == '0);
        flag[FLAG_V] <= v;
      end
      if (upd_n)
        flag[FLAG_N] <= res[M] & ~v;
    end else if (mul_done) begin
      out          <= mul_prod[DSIZE-1:0];
      out_valid    <= 1'b1;
      flag[FLAG_Z] <= (mul_prod[DSIZE-1:0] == '0);
      flag[FLAG_V] <= (mul_prod[2*DSIZE-1:DSIZE] != '0);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
